fetch_unit: RTL and testbench

Instruction fetch and PC-update unit for the multicycle CPU. It is the consumer of the control unit's PC/branch strobes (`pc_write`/EscCP, `pc_write_cond`/EscCondCP, `pc_src`/FonteCP). It holds the PC, fetches 16-bit instructions from instruction memory over a req/ack handshake, latches the instruction register, and exposes the decoded fields back to the control unit and datapath. It sits between instruction memory and the control FSM. The control FSM is clock-enabled by `instr_valid`.

---
 rtl/fetch_unit_if.sv | 13 +
 rtl/fetch_unit.sv | 133 +++++++++++++
 tb/tb_fetch_unit.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_unit_if.sv
// Instruction-memory fetch channel: req/addr from the fetch unit, ack/rdata from memory.
// rdata is valid when both req and ack are high.
interface fetch_unit_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic              ack;
  logic [15:0]       rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// Multicycle-CPU fetch unit: holds PC and IR, fetches over req/ack, applies PC strobes.
// Optional fetch watchdog enabled by defining FETCH_TIMEOUT_EN.
module fetch_unit #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_write,
  input  logic              pc_write_cond,
  input  logic [1:0]        pc_src,
  input  logic              zero,
  fetch_unit_if.master      imem,
  output logic [ADDR_W-1:0] pc,
  output logic              instr_valid,
  output logic [3:0]        opcode,
  output logic [3:0]        rd,
  output logic [3:0]        rs,
  output logic [3:0]        rt,
  output logic [7:0]        imm8,
  output logic [11:0]       jtarget,
  output logic              fetch_err
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_VALID} state_t;

  state_t            state, state_nxt;
  logic [15:0]       ir;
  logic              req;
  logic              load_ir;
  logic              load_pc;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] br_target;
  logic [ADDR_W-1:0] jmp_target;
  logic [ADDR_W-1:0] next_pc;
  logic signed [7:0] imm_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    req         = 1'b0;
    instr_valid = 1'b0;
    load_ir     = 1'b0;
    load_pc     = 1'b0;
    case (state)
      S_IDLE:  state_nxt = S_FETCH;
      S_FETCH: begin
        req = 1'b1;
        if (imem.ack) begin
          load_ir   = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        instr_valid = 1'b1;
        if (pc_write || pc_write_cond) begin
          load_pc   = 1'b1;
          state_nxt = S_FETCH;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign imem.req  = req;
  assign imem.addr = pc;

  // The size casts sign-extend the branch offset and zero-extend/truncate the jump field.
  assign imm_s      = ir[7:0];
  assign pc_inc     = pc + ADDR_W'(1);
  assign br_target  = pc_inc + ADDR_W'(imm_s);
  assign jmp_target = ADDR_W'(ir[11:0]);

  always_comb begin
    next_pc = pc_inc;
    if (pc_write_cond) begin
      next_pc = zero ? br_target : pc_inc;
    end else begin
      case (pc_src)
        2'b01:   next_pc = br_target;
        2'b10:   next_pc = jmp_target;
        default: next_pc = pc_inc;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc <= '0;
      ir <= '0;
    end else begin
      if (load_ir) ir <= imem.rdata;
      if (load_pc) pc <= next_pc;
    end
  end

  assign opcode  = ir[15:12];
  assign rd      = ir[11:8];
  assign rs      = ir[7:4];
  assign rt      = ir[3:0];
  assign imm8    = ir[7:0];
  assign jtarget = ir[11:0];

`ifdef FETCH_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] wd_cnt;

  // Counter idles at zero outside S_FETCH, so every entry into S_FETCH starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt    <= '0;
      fetch_err <= 1'b0;
    end else if (state != S_FETCH || imem.ack) begin
      wd_cnt <= '0;
    end else if (wd_cnt == CNT_W'(TIMEOUT - 1)) begin
      wd_cnt    <= '0;
      fetch_err <= 1'b1;
    end else begin
      wd_cnt <= wd_cnt + CNT_W'(1);
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign fetch_err      = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected (pc, IR) pushed on each strobe, popped on instr_valid rise.
// Watchdog expectations follow FETCH_TIMEOUT_EN.
module tb_fetch_unit;
  localparam int unsigned ADDR_W = 8;
`ifdef FETCH_TIMEOUT_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    logic [7:0]  pc;
    logic [15:0] ir;
  } exp_t;

  logic              clk = 1'b0;
  logic              rst;
  logic              pc_write = 1'b0;
  logic              pc_write_cond = 1'b0;
  logic [1:0]        pc_src = 2'b00;
  logic              zero = 1'b0;
  logic [ADDR_W-1:0] pc;
  logic              instr_valid;
  logic [3:0]        opcode, rd, rs, rt;
  logic [7:0]        imm8;
  logic [11:0]       jtarget;
  logic              fetch_err;

  logic [15:0]  mem [256];
  int unsigned  ack_delay = 0;
  int unsigned  wcnt = 0;
  logic         spurious = 1'b0;
  logic [7:0]   cur_pc = '0;
  exp_t         sb[$];
  exp_t         mon_e;
  logic         prev_valid = 1'b0;
  int unsigned  n_tests = 0;
  int unsigned  n_fail = 0;

  always #5 clk = ~clk;

  fetch_unit_if #(.ADDR_W(ADDR_W)) imem ();

  fetch_unit #(.ADDR_W(ADDR_W), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .pc_src(pc_src), .zero(zero),
    .imem(imem.master),
    .pc(pc), .instr_valid(instr_valid),
    .opcode(opcode), .rd(rd), .rs(rs), .rt(rt), .imm8(imm8), .jtarget(jtarget),
    .fetch_err(fetch_err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_pc(input logic [7:0] p, input logic [15:0] ir,
                                          input logic wc, input logic [1:0] src, input logic z);
    logic [7:0] inc;
    inc = p + 8'd1;
    if (wc) return z ? inc + ir[7:0] : inc;
    case (src)
      2'b01:   return inc + ir[7:0];
      2'b10:   return ir[7:0];
      default: return inc;
    endcase
  endfunction

  // Memory responder: ack after ack_delay request cycles, or a forced stray ack.
  always @(negedge clk) begin
    if (spurious) begin
      imem.ack   = 1'b1;
      imem.rdata = 16'hDEAD;
    end else if (imem.req === 1'b1) begin
      if (wcnt >= ack_delay) begin
        imem.ack   = 1'b1;
        imem.rdata = mem[imem.addr];
        wcnt       = 0;
      end else begin
        imem.ack = 1'b0;
        wcnt++;
      end
    end else begin
      imem.ack = 1'b0;
      wcnt     = 0;
    end
  end

  always @(negedge clk) begin
    if (instr_valid === 1'b1 && !prev_valid) begin
      if (sb.size() == 0) begin
        check("sb_pending", 32'(sb.size()), 32'd1);
      end else begin
        mon_e = sb.pop_front();
        check("sb_pc",      32'(pc),      32'(mon_e.pc));
        check("sb_opcode",  32'(opcode),  32'(mon_e.ir[15:12]));
        check("sb_rd",      32'(rd),      32'(mon_e.ir[11:8]));
        check("sb_rs",      32'(rs),      32'(mon_e.ir[7:4]));
        check("sb_rt",      32'(rt),      32'(mon_e.ir[3:0]));
        check("sb_imm8",    32'(imm8),    32'(mon_e.ir[7:0]));
        check("sb_jtarget", 32'(jtarget), 32'(mon_e.ir[11:0]));
      end
    end
    prev_valid = (instr_valid === 1'b1);
  end

  task automatic wait_valid(input int unsigned limit);
    int unsigned n = 0;
    while (instr_valid !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    check("valid_wait", 32'(instr_valid), 32'd1);
  endtask

  task automatic strobe(input logic w, input logic wc, input logic [1:0] src, input logic z);
    logic [7:0] np;
    @(negedge clk);
    np            = model_pc(cur_pc, mem[cur_pc], wc, src, z);
    pc_write      = w;
    pc_write_cond = wc;
    pc_src        = src;
    zero          = z;
    @(posedge clk);
    #1;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'b00;
    zero          = 1'b0;
    check("pc_update",  32'(pc),          32'(np));
    check("valid_drop", 32'(instr_valid), 32'd0);
    check("req_next",   32'(imem.req),    32'd1);
    check("addr_next",  32'(imem.addr),   32'(np));
    cur_pc = np;
    sb.push_back(exp_t'{np, mem[np]});
  endtask

  initial begin
    rst = 1'b1;
    for (int unsigned i = 0; i < 256; i++) mem[i] = 16'(32'h7000 + i);
    mem[8'h00] = 16'h1234;
    mem[8'h01] = 16'hB005;
    mem[8'h04] = 16'hB005;
    mem[8'h05] = 16'hC0FE;
    mem[8'h06] = 16'hB03C;
    mem[8'h3C] = 16'hB0FF;
    mem[8'hFF] = 16'h5A5A;

    repeat (3) @(posedge clk);
    #1;
    check("rst_pc",     32'(pc),          32'd0);
    check("rst_valid",  32'(instr_valid), 32'd0);
    check("rst_req",    32'(imem.req),    32'd0);
    check("rst_opcode", 32'(opcode),      32'd0);
    check("rst_err",    32'(fetch_err),   32'd0);

    @(negedge clk);
    rst    = 1'b0;
    cur_pc = '0;
    sb.push_back(exp_t'{8'h00, mem[0]});
    @(posedge clk);
    #1;
    check("first_req",   32'(imem.req),    32'd1);
    check("first_addr",  32'(imem.addr),   32'd0);
    check("first_valid", 32'(instr_valid), 32'd0);
    @(posedge clk);
    #1;
    check("valid_cycle2", 32'(instr_valid), 32'd1);
    check("opcode_1234",  32'(opcode),      32'h1);

    // Three wait cycles; strobes driven during the fetch must be ignored.
    ack_delay = 3;
    strobe(1'b1, 1'b0, 2'b00, 1'b0);
    for (int unsigned i = 0; i < 4; i++) begin
      check("hold_req",   32'(imem.req),    32'd1);
      check("hold_addr",  32'(imem.addr),   32'd1);
      check("hold_valid", 32'(instr_valid), 32'd0);
      check("hold_pc",    32'(pc),          32'd1);
      pc_write = (i < 3);
      pc_src   = (i < 3) ? 2'b10 : 2'b00;
      @(posedge clk);
      #1;
    end
    check("valid_after_ack", 32'(instr_valid), 32'd1);
    check("pc_after_ignored", 32'(pc), 32'd1);

    spurious = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    spurious = 1'b0;
    check("ir_hold_op",  32'(opcode),  32'hB);
    check("ir_hold_jt",  32'(jtarget), 32'h005);
    check("ir_hold_vld", 32'(instr_valid), 32'd1);

    ack_delay = 0;
    strobe(1'b1, 1'b0, 2'b10, 1'b0);  // 1 -> 0x05
    wait_valid(10);
    strobe(1'b1, 1'b1, 2'b01, 1'b1);  // 0x05 taken -> 0x04
    wait_valid(10);
    strobe(1'b1, 1'b0, 2'b10, 1'b0);  // 0x04 -> 0x05
    wait_valid(10);
    strobe(1'b1, 1'b1, 2'b01, 1'b0);  // 0x05 not taken -> 0x06
    wait_valid(10);
    strobe(1'b1, 1'b0, 2'b10, 1'b0);  // 0x06 -> 0x3C
    wait_valid(10);
    strobe(1'b1, 1'b0, 2'b10, 1'b0);  // 0x3C -> 0xFF
    wait_valid(10);
    strobe(1'b1, 1'b0, 2'b00, 1'b0);  // 0xFF -> 0x00 wrap
    wait_valid(10);
    strobe(1'b0, 1'b1, 2'b10, 1'b1);  // cond overrides jump: 0 + 1 + 0x34
    wait_valid(10);
    check("branch_override", 32'(pc), 32'h35);
    strobe(1'b1, 1'b0, 2'b11, 1'b0);  // src 11 -> PC+1
    wait_valid(10);

    ack_delay = 20;
    strobe(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (5) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_req",   32'(imem.req),    32'd0);
    check("midrst_pc",    32'(pc),          32'd0);
    check("midrst_valid", 32'(instr_valid), 32'd0);
    sb.delete();
    ack_delay = 0;
    @(negedge clk);
    rst    = 1'b0;
    cur_pc = '0;
    sb.push_back(exp_t'{8'h00, mem[0]});
    @(posedge clk);
    #1;
    check("restart_req",  32'(imem.req),  32'd1);
    check("restart_addr", 32'(imem.addr), 32'd0);
    wait_valid(10);

    ack_delay = 30;
    strobe(1'b1, 1'b0, 2'b00, 1'b0);
    repeat (14) @(posedge clk);
    #1;
    check("err_before", 32'(fetch_err), 32'd0);
    @(posedge clk);
    #1;
    check("err_expiry", 32'(fetch_err), 32'(EXP_ERR));
    check("err_req",    32'(imem.req),  32'd1);
    check("err_addr",   32'(imem.addr), 32'd1);
    wait_valid(40);
    check("err_sticky", 32'(fetch_err), 32'(EXP_ERR));
    @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);

    rst = 1'b1;
    #1;
    check("err_cleared", 32'(fetch_err),   32'd0);
    check("final_valid", 32'(instr_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
